// File: rtl/crypto_pkg.sv
// ============================================================================
// Module   : crypto_pkg
// Brief    : Shared widths and writeback entry type for the crypto datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

package crypto_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Width of an occupancy counter that must be able to hold the value depth itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_if.sv
// ============================================================================
// Module   : wb_arbiter_if
// Brief    : Writeback bus bundle: ALU/crypto results in, register-file port out.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface wb_arbiter_if
    import crypto_pkg::*;
#(
    parameter int DATA_W   = crypto_pkg::DATA_W,
    parameter int ADDR_W   = crypto_pkg::ADDR_W,
    parameter int CQ_DEPTH = 4
) ();

    localparam int CNT_W = cnt_w(CQ_DEPTH);
    localparam int NREG  = 2 ** ADDR_W;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              cu_valid;
    logic              cu_ready;
    logic [ADDR_W-1:0] cu_rd;
    logic [DATA_W-1:0] cu_data;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [NREG-1:0]   busy_mask;
    logic [CNT_W-1:0]  cq_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output cu_valid, cu_rd, cu_data,
        output issue_valid, issue_rd,
        input  cu_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  busy_mask, cq_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  cu_valid, cu_rd, cu_data,
        input  issue_valid, issue_rd,
        output cu_ready,
        output rf_we, rf_waddr, rf_wdata,
        output busy_mask, cq_count
    );

endinterface

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module   : wb_fifo
// Brief    : Synchronous circular FIFO with occupancy count (DEPTH power of 2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_fifo
    import crypto_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    push_i,
    input  wire logic [WIDTH-1:0]        wdata_i,
    input  wire logic                    pop_i,
    output logic      [WIDTH-1:0]        rdata_o,
    output logic                         empty_o,
    output logic      [cnt_w(DEPTH)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign w_do_pop  = pop_i && (count_q != '0);

    // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Brief    : Writeback arbiter (ALU over crypto FIFO) with RAW busy scoreboard.
//            Optional macro WB_BYPASS_EN: crypto result skips an empty FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter
    import crypto_pkg::*;
#(
    parameter int DATA_W   = crypto_pkg::DATA_W,
    parameter int ADDR_W   = crypto_pkg::ADDR_W,
    parameter int CQ_DEPTH = 4
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    wb_arbiter_if.slave bus
);

    localparam int CNT_W = cnt_w(CQ_DEPTH);
    localparam int NREG  = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            w_cu_entry;
    entry_t            w_head;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_cu_ready;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;

    logic              w_sel_valid;
    logic              w_sel_crypto;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;
    logic [NREG-1:0]   w_clr_vec;
    logic [NREG-1:0]   w_set_vec;

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]   busy_q, busy_d;

    // Readiness depends only on registered occupancy, never on a same-cycle pop.
    assign w_cu_ready = (w_fifo_count != CNT_W'(CQ_DEPTH));

`ifdef WB_BYPASS_EN
    assign w_bypass = !bus.alu_valid && w_fifo_empty && bus.cu_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push     = bus.cu_valid && w_cu_ready && !w_bypass;
    assign w_pop      = !bus.alu_valid && !w_fifo_empty;
    assign w_cu_entry = '{rd: bus.cu_rd, data: bus.cu_data};

    wb_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (CQ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .wdata_i (w_cu_entry),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_crypto = 1'b0;
        w_sel_rd     = '0;
        w_sel_data   = '0;
        if (bus.alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = bus.alu_rd;
            w_sel_data  = bus.alu_data;
        end else if (w_pop) begin
            w_sel_valid  = 1'b1;
            w_sel_crypto = 1'b1;
            w_sel_rd     = w_head.rd;
            w_sel_data   = w_head.data;
        end else if (w_bypass) begin
            w_sel_valid  = 1'b1;
            w_sel_crypto = 1'b1;
            w_sel_rd     = bus.cu_rd;
            w_sel_data   = bus.cu_data;
        end
    end

    always_comb begin
        rf_we_d    = w_sel_valid && (w_sel_rd != '0);
        rf_waddr_d = w_sel_valid ? w_sel_rd : rf_waddr_q;
        rf_wdata_d = w_sel_valid ? w_sel_data : rf_wdata_q;
    end

    // Set is OR-ed in after the clear so a same-cycle reissue keeps the bit busy.
    always_comb begin
        w_clr_vec = '0;
        w_set_vec = '0;
        if (w_sel_crypto && rf_we_d)
            w_clr_vec = NREG'(1) << w_sel_rd;
        if (bus.issue_valid && (bus.issue_rd != '0))
            w_set_vec = NREG'(1) << bus.issue_rd;
        busy_d    = (busy_q & ~w_clr_vec) | w_set_vec;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.cu_ready  = w_cu_ready;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.busy_mask = busy_q;
    assign bus.cq_count  = w_fifo_count;

`ifndef SYNTHESIS
    // Decode must never let the ALU overwrite a register still owed a crypto result.
    always @(posedge clk) begin
        if (rst_n && bus.alu_valid && (bus.alu_rd != '0)) begin
            assert (!busy_q[bus.alu_rd])
                else $error("wb_arbiter: ALU write to busy register %0d", bus.alu_rd);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed self-checking bench for wb_arbiter (honours WB_BYPASS_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter;
    import crypto_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CQ_DEPTH(DEPTH)) bus ();

    wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CQ_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.cu_valid    = 1'b0;
        bus.cu_rd       = '0;
        bus.cu_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
    endtask

    task automatic check_rf(input string tag, input logic we, input int addr, input logic [31:0] data);
        check({tag, "_we"}, 64'(bus.rf_we), 64'(we));
        if (we) begin
            check({tag, "_addr"}, 64'(bus.rf_waddr), 64'(addr));
            check({tag, "_data"}, 64'(bus.rf_wdata), 64'(data));
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_we",    64'(bus.rf_we),     64'd0);
        check("rst_count", 64'(bus.cq_count),  64'd0);
        check("rst_busy",  64'(bus.busy_mask), 64'd0);
        check("rst_ready", 64'(bus.cu_ready),  64'd1);
        rst_n = 1'b1;
        tick();

        // ALU path: one-cycle latency, rd==0 suppressed.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'hDEAD_BEEF;
        tick();
        check_rf("alu7", 1'b1, 7, 32'hDEAD_BEEF);
        bus.alu_rd = 5'd0; bus.alu_data = 32'h1234_5678;
        tick();
        check_rf("alu0", 1'b0, 0, 32'h0);
        bus.alu_valid = 1'b0;
        tick();
        check_rf("idle", 1'b0, 0, 32'h0);

        // Crypto ordering and scoreboard clear.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
        tick();
        check("iss4_busy", 64'(bus.busy_mask), 64'h10);
        bus.issue_rd = 5'd5;
        tick();
        check("iss5_busy", 64'(bus.busy_mask), 64'h30);
        bus.issue_valid = 1'b0;
        bus.cu_valid = 1'b1; bus.cu_rd = 5'd4; bus.cu_data = 32'h11;
        tick();
`ifdef WB_BYPASS_EN
        check_rf("byp4", 1'b1, 4, 32'h11);
        check("byp4_busy",  64'(bus.busy_mask), 64'h20);
        check("byp4_count", 64'(bus.cq_count),  64'd0);
`else
        check_rf("cq_n1", 1'b0, 0, 32'h0);
        check("cq_n1_count", 64'(bus.cq_count), 64'd1);
`endif
        bus.cu_rd = 5'd5; bus.cu_data = 32'h22;
        tick();
`ifdef WB_BYPASS_EN
        check_rf("byp5", 1'b1, 5, 32'h22);
        check("byp5_busy", 64'(bus.busy_mask), 64'h00);
`else
        check_rf("cq_w4", 1'b1, 4, 32'h11);
        check("cq_w4_busy",  64'(bus.busy_mask), 64'h20);
        check("cq_w4_count", 64'(bus.cq_count),  64'd1);
`endif
        bus.cu_valid = 1'b0;
        tick();
`ifdef WB_BYPASS_EN
        check_rf("byp_idle", 1'b0, 0, 32'h0);
`else
        check_rf("cq_w5", 1'b1, 5, 32'h22);
        check("cq_w5_busy", 64'(bus.busy_mask), 64'h00);
`endif
        check("cq_count0", 64'(bus.cq_count), 64'd0);
        tick();
        check_rf("cq_idle", 1'b0, 0, 32'h0);

        // Same-cycle clear and reissue of r3: set wins.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        tick();
        check("iss3_busy", 64'(bus.busy_mask), 64'h08);
        bus.cu_valid = 1'b1; bus.cu_rd = 5'd3; bus.cu_data = 32'h33;
`ifndef WB_BYPASS_EN
        bus.issue_valid = 1'b0;
        tick();
        bus.cu_valid = 1'b0;
        bus.issue_valid = 1'b1;
`endif
        tick();
        check_rf("coll_w3", 1'b1, 3, 32'h33);
        check("coll_busy", 64'(bus.busy_mask), 64'h08);
        clear_inputs();
        bus.cu_valid = 1'b1; bus.cu_rd = 5'd3; bus.cu_data = 32'h34;
        tick();
        bus.cu_valid = 1'b0;
        tick();
        check("r3_cleared", 64'(bus.busy_mask), 64'h00);

        // Latency into an empty FIFO with the ALU idle.
        bus.cu_valid = 1'b1; bus.cu_rd = 5'd9; bus.cu_data = 32'hCAFE;
        tick();
        bus.cu_valid = 1'b0;
`ifdef WB_BYPASS_EN
        check_rf("lat_n1", 1'b1, 9, 32'hCAFE);
        check("lat_n1_count", 64'(bus.cq_count), 64'd0);
`else
        check_rf("lat_n1", 1'b0, 0, 32'h0);
        check("lat_n1_count", 64'(bus.cq_count), 64'd1);
        tick();
        check_rf("lat_n2", 1'b1, 9, 32'hCAFE);
`endif
        tick();

        // Starvation: ALU holds the port, FIFO fills to DEPTH then back-pressures.
        for (int i = 0; i < 10; i++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'(i + 1); bus.alu_data = 32'hA000 + 32'(i);
            bus.cu_valid  = 1'b1; bus.cu_rd  = 5'(16 + i); bus.cu_data = 32'hC0 + 32'(i);
            check($sformatf("stv_ready%0d", i), 64'(bus.cu_ready), 64'(i < DEPTH));
            tick();
            check_rf($sformatf("stv_alu%0d", i), 1'b1, i + 1, 32'hA000 + 32'(i));
        end
        check("stv_full",  64'(bus.cq_count), 64'(DEPTH));
        check("stv_ready", 64'(bus.cu_ready), 64'd0);
        clear_inputs();
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            check_rf($sformatf("drain%0d", k), 1'b1, 16 + k, 32'hC0 + 32'(k));
        end
        tick();
        check_rf("drain_idle", 1'b0, 0, 32'h0);
        check("drain_count", 64'(bus.cq_count), 64'd0);

        // Asynchronous reset with three queued entries and busy bits 4 and 7.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
        tick();
        bus.issue_rd = 5'd7;
        tick();
        bus.issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'(i);
            bus.cu_valid  = 1'b1; bus.cu_rd  = 5'(20 + i); bus.cu_data = 32'h50 + 32'(i);
            tick();
        end
        check("pre_rst_count", 64'(bus.cq_count),  64'd3);
        check("pre_rst_busy",  64'(bus.busy_mask), 64'h90);
        check("pre_rst_we",    64'(bus.rf_we),     64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we",    64'(bus.rf_we),     64'd0);
        check("arst_count", 64'(bus.cq_count),  64'd0);
        check("arst_busy",  64'(bus.busy_mask), 64'd0);
        check("arst_ready", 64'(bus.cu_ready),  64'd1);
        tick();
        check("arst_hold_we", 64'(bus.rf_we), 64'd0);
        clear_inputs();
        rst_n = 1'b1;
        tick();
        check("post_rst_we", 64'(bus.rf_we), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
